// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - widths, field positions, opcodes, states and select codes for control_unit
package control_pkg;

    localparam int WORD_SIZE  = 8;
    localparam int STATE_SIZE = 4;
    localparam int SEL1_SIZE  = 3;
    localparam int SEL2_SIZE  = 2;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int SRC_MSB = 3;
    localparam int SRC_LSB = 2;
    localparam int DST_MSB = 1;
    localparam int DST_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    localparam logic [SEL1_SIZE-1:0] SEL1_PC   = 3'd4;
    localparam logic [SEL2_SIZE-1:0] SEL2_ALU  = 2'd0;
    localparam logic [SEL2_SIZE-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [SEL2_SIZE-1:0] SEL2_MEM  = 2'd2;

    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction/flag inputs and datapath control strobes of control_unit
interface control_unit_if;
    import control_pkg::*;

    logic [WORD_SIZE-1:0] instruction;
    logic                 zero;
    logic                 Load_R0;
    logic                 Load_R1;
    logic                 Load_R2;
    logic                 Load_R3;
    logic                 Load_PC;
    logic                 Inc_PC;
    logic [SEL1_SIZE-1:0] Sel_Bus_1_Mux;
    logic [SEL2_SIZE-1:0] Sel_Bus_2_Mux;
    logic                 Load_IR;
    logic                 Load_Add_R;
    logic                 Load_Reg_Y;
    logic                 Load_Reg_Z;
    logic                 write;
    logic                 halted;

    modport master (
        input  instruction, zero,
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
               Load_Reg_Y, Load_Reg_Z, write, halted
    );

    modport slave (
        output instruction, zero,
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
               Load_Reg_Y, Load_Reg_Z, write, halted
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle fetch/decode/execute controller FSM
module control_unit
    import control_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);

    state_t state_q, state_d;

    logic [3:0]           opcode;
    logic [1:0]           src;
    logic [1:0]           dest;
    logic [3:0]           load_r;
    logic [SEL1_SIZE-1:0] sel1;
    logic [SEL2_SIZE-1:0] sel2;
    logic                 load_pc, inc_pc, load_ir, load_add_r;
    logic                 load_reg_y, load_reg_z, write_o, halted_o;

    assign opcode = bus.instruction[OP_MSB:OP_LSB];
    assign src    = bus.instruction[SRC_MSB:SRC_LSB];
    assign dest   = bus.instruction[DST_MSB:DST_LSB];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_r     = 4'b0000;
        sel1       = '0;
        sel2       = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write_o    = 1'b0;
        halted_o   = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
                state_d = S_FET2;
            end
            S_FET2: begin
                sel2 = SEL2_MEM; load_ir = 1'b1; inc_pc = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: state_d = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel1 = {1'b0, src}; load_reg_y = 1'b1;
                        state_d = S_EX1;
                    end
                    OP_NOT: begin
                        sel1 = {1'b0, src}; sel2 = SEL2_ALU;
                        load_reg_z = 1'b1; load_r = reg_onehot(dest);
                        state_d = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
                        state_d = (opcode == OP_RD) ? S_RD1 :
                                  (opcode == OP_WR) ? S_WR1 : S_BR1;
                    end
                    OP_BRZ: begin
                        // Not taken: step PC past the inline address byte.
                        if (bus.zero) begin
                            sel1 = SEL1_PC; sel2 = SEL2_BUS1; load_add_r = 1'b1;
                            state_d = S_BR1;
                        end else begin
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_EX1: begin
                sel1 = {1'b0, dest}; sel2 = SEL2_ALU;
                load_reg_z = 1'b1; load_r = reg_onehot(dest);
                state_d = S_FET1;
            end
            S_RD1, S_WR1: begin
                sel2 = SEL2_MEM; load_add_r = 1'b1; inc_pc = 1'b1;
                state_d = (state_q == S_RD1) ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                sel2 = SEL2_MEM; load_r = reg_onehot(dest);
                state_d = S_FET1;
            end
            S_WR2: begin
                sel1 = {1'b0, src}; write_o = 1'b1;
                state_d = S_FET1;
            end
            S_BR1: begin
                sel2 = SEL2_MEM; load_add_r = 1'b1;
                state_d = S_BR2;
            end
            S_BR2: begin
                sel2 = SEL2_MEM; load_pc = 1'b1;
                state_d = S_FET1;
            end
            S_HALT: halted_o = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    assign bus.Load_R0       = load_r[0];
    assign bus.Load_R1       = load_r[1];
    assign bus.Load_R2       = load_r[2];
    assign bus.Load_R3       = load_r[3];
    assign bus.Load_PC       = load_pc;
    assign bus.Inc_PC        = inc_pc;
    assign bus.Sel_Bus_1_Mux = sel1;
    assign bus.Sel_Bus_2_Mux = sel2;
    assign bus.Load_IR       = load_ir;
    assign bus.Load_Add_R    = load_add_r;
    assign bus.Load_Reg_Y    = load_reg_y;
    assign bus.Load_Reg_Z    = load_reg_z;
    assign bus.write         = write_o;
    assign bus.halted        = halted_o;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed vector bench for control_unit
module tb_control_unit;

    typedef struct packed {
        logic       halted;
        logic       write;
        logic       load_reg_z;
        logic       load_reg_y;
        logic       load_add_r;
        logic       load_ir;
        logic       inc_pc;
        logic       load_pc;
        logic [3:0] load_r;
        logic [2:0] sel1;
        logic [1:0] sel2;
    } outs_t;

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        outs_t      exp;
    } vec_t;

    localparam logic [7:0] HLT = 8'h80;
    localparam logic [7:0] WRT = 8'h40;
    localparam logic [7:0] LZ  = 8'h20;
    localparam logic [7:0] LY  = 8'h10;
    localparam logic [7:0] LA  = 8'h08;
    localparam logic [7:0] LIR = 8'h04;
    localparam logic [7:0] INC = 8'h02;
    localparam logic [7:0] LPC = 8'h01;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t o(input logic [2:0] s1, input logic [1:0] s2,
                                input logic [7:0] f, input logic [3:0] r);
        outs_t x;
        x = {f, r, s1, s2};
        return x;
    endfunction

    function automatic outs_t actual();
        outs_t x;
        x = {bus.halted, bus.write, bus.Load_Reg_Z, bus.Load_Reg_Y, bus.Load_Add_R,
             bus.Load_IR, bus.Inc_PC, bus.Load_PC,
             bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0,
             bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux};
        return x;
    endfunction

    task automatic check(input string nm, input outs_t exp);
        outs_t a;
        a = actual();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h", nm, a, exp);
        end
    endtask

    task automatic add(input logic [7:0] instr, input logic zero, input outs_t exp);
        vec_t v;
        v.instr = instr;
        v.zero  = zero;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input logic [7:0] instr);
        add(instr, 1'b0, o(3'd4, 2'd1, LA, 4'b0000));
        add(instr, 1'b0, o(3'd0, 2'd2, LIR | INC, 4'b0000));
    endtask

    task automatic step_check(input string nm, input outs_t exp);
        @(negedge clk);
        #1;
        check(nm, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        add(8'h16, 1'b0, o(3'd0, 2'd0, 8'h00, 4'b0000));
        add_fetch(8'h16);
        add(8'h16, 1'b0, o(3'd1, 2'd0, LY, 4'b0000));
        add(8'h16, 1'b0, o(3'd2, 2'd0, LZ, 4'b0100));
        add_fetch(8'h5B);
        add(8'h5B, 1'b0, o(3'd4, 2'd1, LA, 4'b0000));
        add(8'h5B, 1'b0, o(3'd0, 2'd2, LA | INC, 4'b0000));
        add(8'h5B, 1'b0, o(3'd0, 2'd2, 8'h00, 4'b1000));
        add_fetch(8'h84);
        add(8'h84, 1'b0, o(3'd0, 2'd0, INC, 4'b0000));
        add_fetch(8'h84);
        add(8'h84, 1'b1, o(3'd4, 2'd1, LA, 4'b0000));
        add(8'h84, 1'b0, o(3'd0, 2'd2, LA, 4'b0000));
        add(8'h84, 1'b0, o(3'd0, 2'd2, LPC, 4'b0000));
        add_fetch(8'h4E);
        add(8'h4E, 1'b1, o(3'd3, 2'd0, LZ, 4'b0100));
        add_fetch(8'h00);
        add(8'h00, 1'b1, o(3'd0, 2'd0, 8'h00, 4'b0000));
        add_fetch(8'h2D);
        add(8'h2D, 1'b0, o(3'd3, 2'd0, LY, 4'b0000));
        add(8'h2D, 1'b0, o(3'd1, 2'd0, LZ, 4'b0010));
        add_fetch(8'h64);
        add(8'h64, 1'b0, o(3'd4, 2'd1, LA, 4'b0000));
        add(8'h64, 1'b0, o(3'd0, 2'd2, LA | INC, 4'b0000));
        add(8'h64, 1'b0, o(3'd1, 2'd0, WRT, 4'b0000));
        add_fetch(8'h33);
        add(8'h33, 1'b0, o(3'd0, 2'd0, LY, 4'b0000));
        add(8'h33, 1'b0, o(3'd3, 2'd0, LZ, 4'b1000));
        add_fetch(8'h70);
        add(8'h70, 1'b0, o(3'd4, 2'd1, LA, 4'b0000));
        add(8'h70, 1'b0, o(3'd0, 2'd2, LA, 4'b0000));
        add(8'h70, 1'b0, o(3'd0, 2'd2, LPC, 4'b0000));
        add_fetch(8'hF0);
        add(8'hF0, 1'b0, o(3'd0, 2'd0, 8'h00, 4'b0000));
        for (int i = 0; i < 10; i++) add(8'hF0, i[0], o(3'd0, 2'd0, HLT, 4'b0000));

        rst             = 1'b0;
        bus.instruction = 8'h16;
        bus.zero        = 1'b0;
        #2;
        check("reset_out", o(3'd0, 2'd0, 8'h00, 4'b0000));
        step_check("reset_held", o(3'd0, 2'd0, 8'h00, 4'b0000));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.instruction = vecs[i].instr;
            bus.zero        = vecs[i].zero;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(negedge clk);
        end

        rst = 1'b0;
        #1;
        check("halt_reset", o(3'd0, 2'd0, 8'h00, 4'b0000));
        @(negedge clk);
        rst = 1'b1;
        bus.instruction = 8'h64;
        #1;
        check("restart_idle", o(3'd0, 2'd0, 8'h00, 4'b0000));
        step_check("restart_fet1", o(3'd4, 2'd1, LA, 4'b0000));
        step_check("restart_fet2", o(3'd0, 2'd2, LIR | INC, 4'b0000));
        step_check("wr_dec", o(3'd4, 2'd1, LA, 4'b0000));
        step_check("wr_wr1", o(3'd0, 2'd2, LA | INC, 4'b0000));
        #2;
        rst = 1'b0;
        #1;
        check("wr_async_rst", o(3'd0, 2'd0, 8'h00, 4'b0000));
        step_check("wr_rst_held", o(3'd0, 2'd0, 8'h00, 4'b0000));
        rst = 1'b1;
        #1;
        check("wr_rst_idle", o(3'd0, 2'd0, 8'h00, 4'b0000));
        step_check("wr_rst_fet1", o(3'd4, 2'd1, LA, 4'b0000));
        step_check("wr_rst_fet2", o(3'd0, 2'd2, LIR | INC, 4'b0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle controller FSM that reads the instruction register output.
- Decodes the opcode, source and destination fields.
- Sequences fetch/decode/execute by driving register load enables, bus-mux selects, PC control and memory write.
- Sits between the instruction register, the Z flag register and the datapath.

Parameters:
word_size, 8, instruction width; opcode = [7:4], src = [3:2], dest = [1:0]
state_size, 4, state register width
sel1_size, 3, Sel_Bus_1_Mux width
sel2_size, 2, Sel_Bus_2_Mux width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
instruction  input  word_size  instruction register contents
zero  input  1  registered ALU zero flag (Reg_Z)
Load_R0..Load_R3  output  1 each  load enables for R0..R3
Load_PC  output  1  load PC from Bus_2
Inc_PC  output  1  increment PC
Sel_Bus_1_Mux  output  sel1_size  0=R0, 1=R1, 2=R2, 3=R3, 4=PC
Sel_Bus_2_Mux  output  sel2_size  0=ALU, 1=Bus_1, 2=memory
Load_IR  output  1  instruction register load
Load_Add_R  output  1  address register load
Load_Reg_Y  output  1  ALU operand Y register load
Load_Reg_Z  output  1  zero flag register load
write  output  1  memory write strobe
halted  output  1  high while in S_halt

Behaviour:
- State register only.
  - rst low: state <= S_idle asynchronously.
  - Otherwise state <= next_state on posedge clk.
- Outputs are combinational from state, instruction and zero.
- Every output not listed for a state is 0, including both selects.
- Reset therefore forces all outputs to 0.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9..15 are illegal and halt.
- S_idle: no outputs; next S_fet1.
- S_fet1: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_fet2.
- S_fet2: Sel2=mem, Load_IR, Inc_PC; next S_dec.
- S_dec, by opcode:
  - NOP: no outputs; next S_fet1.
  - ADD/SUB/AND: Sel1=src, Load_Reg_Y; next S_ex1.
  - NOT: Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
  - RD, WR, BR: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_rd1, S_wr1, S_br1 respectively.
  - BRZ with zero=1: same outputs as BR; next S_br1.
  - BRZ with zero=0: Inc_PC only (skip address byte); next S_fet1.
  - Illegal opcode: no outputs; next S_halt.
- S_ex1: Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
- S_rd1: Sel2=mem, Load_Add_R, Inc_PC; next S_rd2.
- S_rd2: Sel2=mem, Load_R[dest]; next S_fet1.
- S_wr1: Sel2=mem, Load_Add_R, Inc_PC; next S_wr2.
- S_wr2: Sel1=src, write; next S_fet1.
- S_br1: Sel2=mem, Load_Add_R; next S_br2.
- S_br2: Sel2=mem, Load_PC; next S_fet1.
- S_halt: halted=1, all else 0; stays until reset.
- Unused state encodings: next S_halt.
- Instruction latency in cycles, counted from S_fet1:
  - NOP = 3; NOT = 3; BRZ not taken = 3.
  - ADD/SUB/AND = 4; RD = 5; WR = 5; BR = 5; BRZ taken = 5.
- Load_R[dest]: exactly one of Load_R0..R3 is asserted, chosen by dest. Never more than one register load per cycle.
- zero is sampled only in S_dec.
- Reset asserted mid-instruction: outputs drop to 0 immediately and asynchronously. The FSM restarts at S_idle.

Decomposition:
- Package control_pkg holds:
  - opcode constants
  - state encoding constants
  - Sel_Bus_1 and Sel_Bus_2 encoding constants
  - field bit positions
- No sub-module. One state register plus one combinational next-state/output block.

Test Plan:
- Reset then release:
  - All outputs are 0 during reset.
  - Cycle 1: S_idle.
  - Cycle 2: Sel1=4, Sel2=1, Load_Add_R=1.
  - Cycle 3: Load_IR=1, Inc_PC=1, Sel2=2.
- instruction=8'h16 (ADD src=R1, dest=R2):
  - S_dec: Sel1=1, Load_Reg_Y=1.
  - S_ex1: Sel1=2, Sel2=0, Load_Reg_Z=1, Load_R2=1.
  - Then back to fetch.
- instruction=8'h5B (RD dest=R3): S_rd1 Inc_PC=1, Load_Add_R=1; S_rd2 Load_R3=1, Sel2=2; 5 cycles in total.
- instruction=8'h84 (BRZ) twice:
  - zero=0: S_dec gives Inc_PC=1, then fetch.
  - zero=1: S_br2 gives Load_PC=1.
- instruction=8'hF0: halted=1 persists for 10 cycles with all other outputs 0. rst low then high restarts the fetch sequence.
- WR (8'h64) with rst pulsed low in S_wr1: write never asserts. The FSM re-enters S_idle.
